// File: rtl/seq_pattern_gen.sv
// Programmable step sequencer: a step counter walks a writable pattern table in one-shot, loop or ping-pong order.
// result/step are registered together (one entry per en cycle); en=0 freezes the sequence, control and table writes still apply.
module seq_pattern_gen #(
  parameter  int WIDTH  = 3,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              en,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [ADDR_W:0]   len,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  result,
  output logic [ADDR_W-1:0] step,
  output logic              busy,
  output logic              done,
  output logic              wrap
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_UP   = 2'd1,
    RUN_DOWN = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [1:0]      MODE_LOOP = 2'b01;
  localparam logic [1:0]      MODE_PP   = 2'b10;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   step_q, step_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [1:0]          mode_q, mode_d;
  logic                done_q, done_d;
  logic                wrap_q, wrap_d;
  logic [WIDTH-1:0]    tbl_q [DEPTH];
  logic [WIDTH-1:0]    tbl_d [DEPTH];
  logic [ADDR_W:0]     last_idx;
  logic [ADDR_W-1:0]   rd_idx;
  logic                rd_tbl;

  always_comb begin
    tbl_d = tbl_q;
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      tbl_d[wr_addr] = wr_data;
    end
  end

  // Reads use tbl_q, so a write on the same edge is only visible one edge later.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    result_d = result_q;
    len_d    = len_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    wrap_d   = 1'b0;
    rd_tbl   = 1'b0;
    rd_idx   = '0;
    last_idx = len_q - (ADDR_W+1)'(1);

    if (stop) begin
      state_d  = IDLE;
      step_d   = '0;
      result_d = '0;
    end else if (start) begin
      len_d   = ((len == '0) || (len > DEPTH_L)) ? DEPTH_L : len;
      mode_d  = mode;
      state_d = RUN_UP;
      step_d  = '0;
      rd_tbl  = 1'b1;
    end else if (en) begin
      case (state_q)
        RUN_UP: begin
          if ({1'b0, step_q} < last_idx) begin
            step_d = step_q + 1'b1;
            rd_tbl = 1'b1;
            rd_idx = step_q + 1'b1;
          end else begin
            case (mode_q)
              MODE_LOOP: begin
                step_d = '0;
                rd_tbl = 1'b1;
                wrap_d = 1'b1;
              end
              MODE_PP: begin
                wrap_d = 1'b1;
                rd_tbl = 1'b1;
                if (len_q >= (ADDR_W+1)'(2)) begin
                  state_d = RUN_DOWN;
                  step_d  = ADDR_W'(len_q - (ADDR_W+1)'(2));
                  rd_idx  = ADDR_W'(len_q - (ADDR_W+1)'(2));
                end else begin
                  step_d = '0;
                end
              end
              default: begin
                state_d  = IDLE;
                step_d   = '0;
                result_d = '0;
                done_d   = 1'b1;
              end
            endcase
          end
        end
        RUN_DOWN: begin
          rd_tbl = 1'b1;
          if (step_q != '0) begin
            step_d = step_q - 1'b1;
            rd_idx = step_q - 1'b1;
          end else begin
            state_d = RUN_UP;
            step_d  = ADDR_W'(1);
            rd_idx  = ADDR_W'(1);
            wrap_d  = 1'b1;
          end
        end
        default: result_d = '0;
      endcase
    end

    if (rd_tbl) begin
      result_d = tbl_q[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      step_q   <= '0;
      result_q <= '0;
      len_q    <= DEPTH_L;
      mode_q   <= 2'b00;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      result_q <= result_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
      tbl_q    <= tbl_d;
    end
  end

  assign result = result_q;
  assign step   = step_q;
  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen, built with DEPTH=6 so out-of-range write addresses exist.
module tb_seq_pattern_gen;

  localparam int WIDTH = 3;
  localparam int DEPTH = 6;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             clr_n = 1'b0;
  logic             en = 1'b0, start = 1'b0, stop = 1'b0, wr_en = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [AW:0]      len = '0;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [WIDTH-1:0] result;
  logic [AW-1:0]    step;
  logic             busy, done, wrap;

  int n_chk  = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] tmod [DEPTH];

  typedef struct {
    logic       e, s, p;
    logic [1:0] m;
    logic [3:0] l;
    logic [2:0] r;
    logic [2:0] st;
    logic       b, d, w;
  } vec_t;

  vec_t vecs[$];

  seq_pattern_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr_n(clr_n), .en(en), .start(start), .stop(stop),
    .mode(mode), .len(len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .result(result), .step(step), .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [2:0] er, input logic [2:0] es,
                     input logic eb, input logic ed, input logic ew);
    n_chk++;
    if (result !== er || step !== es || busy !== eb || done !== ed || wrap !== ew) begin
      n_fail++;
      $display("FAIL %s: got result=%b step=%0d busy=%b done=%b wrap=%b, expected result=%b step=%0d busy=%b done=%b wrap=%b",
               nm, result, step, busy, done, wrap, er, es, eb, ed, ew);
    end
  endtask

  task automatic cyc(input logic e, input logic s, input logic p,
                     input logic [1:0] m, input logic [3:0] l);
    en = e; start = s; stop = p; mode = m; len = l;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0;
  endtask

  function automatic vec_t mk(input logic e, input logic s, input logic p, input logic [1:0] m,
                              input logic [3:0] l, input logic [2:0] r, input logic [2:0] st,
                              input logic b, input logic d, input logic w);
    vec_t v;
    v.e = e; v.s = s; v.p = p; v.m = m; v.l = l;
    v.r = r; v.st = st; v.b = b; v.d = d; v.w = w;
    return v;
  endfunction

  // One-shot pass over DEPTH entries against the bench's table model.
  task automatic run_oneshot(input string nm, input logic [3:0] l);
    cyc(1, 1, 0, 2'b00, l);
    chk($sformatf("%s_s0", nm), tmod[0], 3'd0, 1, 0, 0);
    for (int i = 1; i < DEPTH; i++) begin
      cyc(1, 0, 0, 2'b00, l);
      chk($sformatf("%s_s%0d", nm, i), tmod[i], 3'(i), 1, 0, 0);
    end
    cyc(1, 0, 0, 2'b00, l);
    chk($sformatf("%s_done", nm), 3'b000, 3'd0, 0, 1, 0);
  endtask

  initial begin
    tmod[0] = 3'b000; tmod[1] = 3'b001; tmod[2] = 3'b011;
    tmod[3] = 3'b101; tmod[4] = 3'b111; tmod[5] = 3'b010;

    // one-shot len 6
    vecs.push_back(mk(1,1,0,2'b00,4'd6, 3'b000,3'd0,1,0,0));
    vecs.push_back(mk(1,0,0,2'b00,4'd6, 3'b001,3'd1,1,0,0));
    vecs.push_back(mk(1,0,0,2'b00,4'd6, 3'b011,3'd2,1,0,0));
    vecs.push_back(mk(1,0,0,2'b00,4'd6, 3'b101,3'd3,1,0,0));
    vecs.push_back(mk(1,0,0,2'b00,4'd6, 3'b111,3'd4,1,0,0));
    vecs.push_back(mk(1,0,0,2'b00,4'd6, 3'b010,3'd5,1,0,0));
    vecs.push_back(mk(1,0,0,2'b00,4'd6, 3'b000,3'd0,0,1,0));
    vecs.push_back(mk(1,0,0,2'b00,4'd6, 3'b000,3'd0,0,0,0));
    // loop len 3
    vecs.push_back(mk(1,1,0,2'b01,4'd3, 3'b000,3'd0,1,0,0));
    vecs.push_back(mk(1,0,0,2'b01,4'd3, 3'b001,3'd1,1,0,0));
    vecs.push_back(mk(1,0,0,2'b01,4'd3, 3'b011,3'd2,1,0,0));
    vecs.push_back(mk(1,0,0,2'b01,4'd3, 3'b000,3'd0,1,0,1));
    vecs.push_back(mk(1,0,0,2'b01,4'd3, 3'b001,3'd1,1,0,0));
    vecs.push_back(mk(1,0,0,2'b01,4'd3, 3'b011,3'd2,1,0,0));
    vecs.push_back(mk(1,0,0,2'b01,4'd3, 3'b000,3'd0,1,0,1));
    vecs.push_back(mk(1,0,1,2'b01,4'd3, 3'b000,3'd0,0,0,0));
    // ping-pong len 4
    vecs.push_back(mk(1,1,0,2'b10,4'd4, 3'b000,3'd0,1,0,0));
    vecs.push_back(mk(1,0,0,2'b10,4'd4, 3'b001,3'd1,1,0,0));
    vecs.push_back(mk(1,0,0,2'b10,4'd4, 3'b011,3'd2,1,0,0));
    vecs.push_back(mk(1,0,0,2'b10,4'd4, 3'b101,3'd3,1,0,0));
    vecs.push_back(mk(1,0,0,2'b10,4'd4, 3'b011,3'd2,1,0,1));
    vecs.push_back(mk(1,0,0,2'b10,4'd4, 3'b001,3'd1,1,0,0));
    vecs.push_back(mk(1,0,0,2'b10,4'd4, 3'b000,3'd0,1,0,0));
    vecs.push_back(mk(1,0,0,2'b10,4'd4, 3'b001,3'd1,1,0,1));
    vecs.push_back(mk(1,0,0,2'b10,4'd4, 3'b011,3'd2,1,0,0));
    // ping-pong len 1
    vecs.push_back(mk(1,1,0,2'b10,4'd1, 3'b000,3'd0,1,0,0));
    vecs.push_back(mk(1,0,0,2'b10,4'd1, 3'b000,3'd0,1,0,1));
    vecs.push_back(mk(1,0,0,2'b10,4'd1, 3'b000,3'd0,1,0,1));
    vecs.push_back(mk(0,0,0,2'b10,4'd1, 3'b000,3'd0,1,0,0));
    vecs.push_back(mk(1,0,0,2'b10,4'd1, 3'b000,3'd0,1,0,1));
    vecs.push_back(mk(0,0,1,2'b10,4'd1, 3'b000,3'd0,0,0,0));

    #3;
    chk("reset", 3'b000, 3'd0, 0, 0, 0);
    @(negedge clk);
    clr_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = tmod[i];
      cyc(0, 0, 0, 2'b00, 4'd0);
      chk($sformatf("wr_idle%0d", i), 3'b000, 3'd0, 0, 0, 0);
    end
    wr_en = 1'b0;

    foreach (vecs[i]) begin
      cyc(vecs[i].e, vecs[i].s, vecs[i].p, vecs[i].m, vecs[i].l);
      chk($sformatf("vec%0d", i), vecs[i].r, vecs[i].st, vecs[i].b, vecs[i].d, vecs[i].w);
    end

    // stall at step 2, then resume; start+stop together goes idle
    cyc(1, 1, 0, 2'b00, 4'd6);
    cyc(1, 0, 0, 2'b00, 4'd6);
    cyc(1, 0, 0, 2'b00, 4'd6);
    chk("stall_pre", tmod[2], 3'd2, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 2'b00, 4'd6);
      chk($sformatf("stall%0d", i), tmod[2], 3'd2, 1, 0, 0);
    end
    cyc(1, 0, 0, 2'b00, 4'd6);
    chk("stall_resume", tmod[3], 3'd3, 1, 0, 0);
    cyc(1, 1, 1, 2'b00, 4'd6);
    chk("start_stop", 3'b000, 3'd0, 0, 0, 0);

    run_oneshot("len0", 4'd0);
    run_oneshot("len9", 4'd9);

    // write entry 1 on the edge the sequencer moves onto it
    cyc(1, 1, 0, 2'b01, 4'd6);
    chk("coll_s0", tmod[0], 3'd0, 1, 0, 0);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 3'b110;
    cyc(1, 0, 0, 2'b01, 4'd6);
    wr_en = 1'b0;
    chk("coll_old", 3'b001, 3'd1, 1, 0, 0);
    tmod[1] = 3'b110;
    for (int i = 2; i < DEPTH; i++) begin
      cyc(1, 0, 0, 2'b01, 4'd6);
      chk($sformatf("coll_s%0d", i), tmod[i], 3'(i), 1, 0, 0);
    end
    cyc(1, 0, 0, 2'b01, 4'd6);
    chk("coll_wrap", tmod[0], 3'd0, 1, 0, 1);
    cyc(1, 0, 0, 2'b01, 4'd6);
    chk("coll_new", 3'b110, 3'd1, 1, 0, 0);
    cyc(0, 0, 1, 2'b01, 4'd6);

    for (int a = DEPTH; a < 8; a++) begin
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = 3'b100;
      cyc(0, 0, 0, 2'b00, 4'd0);
    end
    wr_en = 1'b0;
    run_oneshot("oob_wr", 4'd6);

    // asynchronous reset in RUN_DOWN, between edges
    cyc(1, 1, 0, 2'b10, 4'd4);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 2'b10, 4'd4);
    chk("rd_pre", tmod[2], 3'd2, 1, 0, 1);
    #2 clr_n = 1'b0;
    #1 chk("async_rst", 3'b000, 3'd0, 0, 0, 0);
    #1 clr_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) tmod[i] = '0;
    run_oneshot("post_rst", 4'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Parametrised successor to the fixed 3-bit step-sequence FSM.
- A synchronous step counter indexes a run-time-writable pattern table. The table entry at the current step drives a registered output.
- Sequence length, run mode (one-shot, loop, ping-pong), start/stop control and stall-enable are all programmable.
- Sits between a control/config master and any downstream logic that needs a repeating or one-shot code sequence.

Parameters:
- WIDTH, 3, bit width of each pattern entry and of result.
- DEPTH, 8, number of table entries (>=2).
- ADDR_W, ceil(log2(DEPTH)), derived and not overridable. Width of step and wr_addr.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- clr_n  in  1  asynchronous active-low reset.
- en  in  1  advance enable; 0 stalls the sequencer. Control inputs and table writes are still accepted while en=0.
- start  in  1  begin or retrigger a sequence.
- stop  in  1  abort to IDLE.
- mode  in  2  00 one-shot, 01 loop, 10 ping-pong, 11 reserved (behaves as one-shot).
- len  in  ADDR_W+1  sequence length; sampled at start.
- wr_en  in  1  table write strobe.
- wr_addr  in  ADDR_W  table write address.
- wr_data  in  WIDTH  table write data.
- result  out  WIDTH  registered pattern output.
- step  out  ADDR_W  current table index.
- busy  out  1  high in RUN_UP or RUN_DOWN.
- done  out  1  one-cycle pulse when a one-shot completes.
- wrap  out  1  one-cycle pulse on each loop restart or ping-pong turn-around.

Behaviour:
- Reset (clr_n=0, asynchronous):
  - state=IDLE; result=0, step=0, busy=0, done=0, wrap=0.
  - All table entries=0; latched len_q=DEPTH, mode_q=00.
- Length rule, applied when len is sampled at start:
  - len=0 or len>DEPTH is latched as DEPTH.
  - Otherwise len_q=len.
  - mode is latched into mode_q on the same edge.
- Table write:
  - On the edge with wr_en=1, entry[wr_addr] is updated.
  - wr_addr>=DEPTH is ignored.
  - Writes are legal in any state and irrespective of en.
  - A read of the same entry on the same edge returns the old value; the new value is visible from the next edge.
- States: IDLE, RUN_UP, RUN_DOWN.
- Control priority per edge: stop > start > en-advance.
- stop=1:
  - Next state IDLE; result=0, step=0.
  - done and wrap are not asserted.
- start=1 (stop=0), from any state, en not required:
  - Latch len_q and mode_q; step=0; result=entry[0]; next state RUN_UP.
  - busy=1 from the following cycle.
  - Retrigger mid-sequence is legal and restarts at 0.
- IDLE with no start: hold result=0.
- RUN_UP with en=1:
  - If step<len_q-1: step+1, and result=entry[step+1].
  - If step==len_q-1, by mode:
    - One-shot: state IDLE, result=0, step=0, done=1 for one cycle.
    - Loop: step=0, result=entry[0], wrap=1 for one cycle.
    - Ping-pong with len_q>=2: state RUN_DOWN, step=len_q-2, result=entry[len_q-2], wrap=1.
    - Ping-pong with len_q=1: step holds 0 and wrap=1 every en cycle.
- RUN_DOWN with en=1:
  - If step>0: step-1, and result=entry[step-1].
  - If step==0: state RUN_UP, step=1, result=entry[1], wrap=1.
  - Endpoints are not repeated: sequence 0,1,..,L-1,L-2,..,0,1,...
- en=0 in a RUN state: step, result and state hold; done and wrap stay 0.
- Latency:
  - result reflects the current step with zero extra latency; it is registered together with step.
  - One table entry is presented per en cycle.
- done and wrap are mutually exclusive and never assert in IDLE except on the completion edge.
- Reset mid-sequence returns immediately to the reset values above; table contents are lost.

Test Plan:
- Reset, then write entries 0..5 = 000,001,011,101,111,010; len=6, mode=00, start, en=1 -> result 000,001,011,101,111,010, then 000 with done=1 for one cycle, busy=0, step=0.
- Same table, mode=01, len=3 -> 000,001,011,000,001,...; wrap=1 on each transition to step 0; done never asserts.
- mode=10, len=4 -> step 0,1,2,3,2,1,0,1,...; wrap on the step 3->2 and step 0->1 edges; len=1 -> step stays 0 with wrap=1 every cycle.
- Start, run to step 2, drop en for 5 cycles -> step=2 and result are held; raise en -> resumes at step 3. Assert start and stop together -> IDLE, result=0.
- len=0 and len=DEPTH+3 -> both run DEPTH steps. Write entry[1]=110 on the same edge step moves to 1 -> old value shown; the next pass shows 110. wr_addr>=DEPTH -> table unchanged.
- Pull clr_n low asynchronously mid-RUN_DOWN (between edges) -> outputs are 0 immediately and all table entries read back 0 after restart.
